// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic ERR_OOR = 1'b1;
  function automatic int off_bits(input int n);
    return $clog2(n / 8);
  endfunction
endpackage

// File: rtl/dmem_bank_ram.sv
// dmem_bank_ram: synchronous single-port byte-masked RAM; a read during a write returns the old word.
module dmem_bank_ram #(
  parameter int N     = 64,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wdata,
  input  logic [N/8-1:0] wmask,
  output logic [N-1:0]  rdata
);
  logic [N-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we)
        for (int i = 0; i < N / 8; i++)
          if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding LSU memory target with fixed response latency
// and out-of-range fault reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          N           = 64,
  parameter int          DEPTH_WORDS = 512,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          LAT         = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [N-1:0]   req_addr,
  input  logic [N-1:0]   req_wdata,
  input  logic [N/8-1:0] req_wmask,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [N-1:0]   resp_rdata,
  output logic           resp_err
);
  localparam int OB = off_bits(N);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [N-1:0] BASE  = BASE_ADDR[N-1:0];
  localparam logic [N-1:0] DEPTH = N'(DEPTH_WORDS);
  state_t state;
  logic [3:0] cnt;
  logic pend_err, pend_ld, ld_sel, oor, accept;
  logic [N-1:0] off, idx, ram_rdata;
  assign off    = req_addr - BASE;
  assign idx    = off >> OB;
  assign oor    = (req_addr < BASE) || (idx >= DEPTH);
  assign accept = req_valid && req_ready;
  // The RAM output register holds the loaded word until the next access, so gating it suffices.
  assign resp_rdata = ld_sel ? ram_rdata : '0;
  dmem_bank_ram #(.N(N), .DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (accept && !oor),
    .we    (req_we),
    .addr  (idx[AW-1:0]),
    .wdata (req_wdata),
    .wmask (req_wmask),
    .rdata (ram_rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      ld_sel     <= 1'b0;
      pend_err   <= 1'b0;
      pend_ld    <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          pend_err  <= oor ? ERR_OOR : 1'b0;
          pend_ld   <= !req_we && !oor;
          if (LAT == 1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= oor ? ERR_OOR : 1'b0;
            ld_sel     <= !req_we && !oor;
          end else begin
            state <= WAIT;
            cnt   <= 4'(LAT - 1);
          end
        end
        WAIT: if (cnt == '0) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= pend_err;
          ld_sel     <= pend_ld;
        end else cnt <= cnt - 4'd1;
        RESP: if (resp_ready) begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          ld_sel     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          ld_sel     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized bench against a word-array memory model of the responder.
module tb_dmem_responder;
  localparam int LAT = 2;
  localparam int DW = 512;
  localparam logic [63:0] BASE = 64'h0;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_we = 0, resp_ready = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [7:0] req_wmask = 0;
  logic req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;
  int errors = 0, checks = 0;
  logic [63:0] ref_mem [DW];

  dmem_responder #(.N(64), .DEPTH_WORDS(DW), .BASE_ADDR(BASE), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_oor(input logic [63:0] a);
    return (a < BASE) || (((a - BASE) >> 3) >= 64'(DW));
  endfunction

  // Applies a request as soon as the responder is idle; updates the model at the accept edge.
  task automatic xact(input logic we, input logic [63:0] a, input logic [63:0] wd,
                      input logic [7:0] m, input int stall);
    logic [63:0] exp_d, h_d;
    logic exp_e, h_e;
    int t, n, idx;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_wmask = m;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    chk("accept_ready", {63'b0, req_ready}, 64'd1);
    if (!req_ready) begin req_valid = 0; return; end
    exp_e = ref_oor(a);
    exp_d = 0;
    if (!exp_e) begin
      idx = int'((a - BASE) >> 3);
      if (we) begin
        for (int b = 0; b < 8; b++) if (m[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else exp_d = ref_mem[idx];
    end
    @(posedge clk);
    #1;
    req_valid = 0; req_we = 1'($urandom); req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom}; req_wmask = 8'($urandom);
    @(negedge clk);
    n = 0;
    while (!resp_valid && n < 40) begin
      resp_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    resp_ready = 0;
    chk("latency", 64'(n), 64'(LAT));
    chk("rdata", resp_rdata, exp_d);
    chk("err", {63'b0, resp_err}, {63'b0, exp_e});
    chk("busy_ready", {63'b0, req_ready}, 64'd0);
    h_d = resp_rdata; h_e = resp_err;
    repeat (stall) begin
      @(negedge clk);
      chk("hold_valid", {63'b0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, h_d);
      chk("hold_err", {63'b0, resp_err}, {63'b0, h_e});
      chk("hold_ready", {63'b0, req_ready}, 64'd0);
    end
    // A request offered on the handshake cycle must not be taken; a wrongly accepted store would corrupt word 0.
    resp_ready = 1; req_valid = 1; req_we = 1; req_addr = 0; req_wmask = 8'hFF;
    req_wdata = {$urandom, $urandom};
    @(posedge clk);
    #1;
    resp_ready = 0; req_valid = 0;
    @(negedge clk);
    chk("post_ready", {63'b0, req_ready}, 64'd1);
    chk("post_valid", {63'b0, resp_valid}, 64'd0);
    chk("post_err", {63'b0, resp_err}, 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", {63'b0, req_ready}, 64'd1);
      chk("idle_valid", {63'b0, resp_valid}, 64'd0);
      chk("idle_err", {63'b0, resp_err}, 64'd0);
      chk("idle_rdata", resp_rdata, 64'd0);
    end
    for (int i = 0; i < DW; i++) xact(1, 64'(i) * 8, {$urandom, $urandom}, 8'hFF, 0);
    xact(1, 64'h10, 64'h1122334455667788, 8'hFF, 0);
    xact(0, 64'h10, 64'h0, 8'h00, 0);
    xact(1, 64'h10, 64'h000000000000AB00, 8'h02, 0);
    xact(0, 64'h10, 64'h0, 8'h00, 0);
    xact(1, 64'h18, 64'hDEADBEEFDEADBEEF, 8'h00, 0);
    xact(0, 64'h18, 64'h0, 8'h00, 0);
    xact(0, 64'h1000, 64'h0, 8'h00, 0);
    xact(1, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0);
    xact(0, 64'h0, 64'h0, 8'h00, 0);
    xact(0, 64'h0FF8, 64'h0, 8'h00, 0);
    xact(0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 8'h00, 0);
    xact(0, 64'h10, 64'h0, 8'h00, 4);
    xact(1, 64'h28, {$urandom, $urandom}, 8'h5A, 4);
    // Reset while a store is in flight: no response, but the write already committed.
    @(negedge clk);
    d = {$urandom, $urandom};
    req_valid = 1; req_we = 1; req_addr = 64'h20; req_wdata = d; req_wmask = 8'hFF;
    chk("rst_accept_ready", {63'b0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 0;
    if (req_ready === 1'b0) ref_mem[4] = d;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rst_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_valid", {63'b0, resp_valid}, 64'd0);
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_resp", {63'b0, resp_valid}, 64'd0);
    end
    xact(0, 64'h20, 64'h0, 8'h00, 0);
    for (int i = 0; i < 300; i++) begin
      logic [63:0] a;
      a = ($urandom_range(0, 99) < 85) ? 64'($urandom_range(0, DW - 1)) * 8 + 64'($urandom_range(0, 7))
                                       : {$urandom, $urandom} | 64'h1000;
      xact(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) xact(0, 64'(i) * 8, 64'h0, 8'h00, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
